// File: rtl/booth_multiplier.sv
// ---------------------------------------------------------------------------
// booth_multiplier
//   Sequential radix-2 Booth multiplier for signed two's-complement operands.
//   One Booth step per clock. A product appears WIDTH+1 edges after the edge
//   that samples start. The valid pulse lasts one cycle. The result is held
//   until the next product is ready.
//
// Ports
//   clk           in   system clock, rising edge
//   reset         in   asynchronous active-high reset
//   start         in   request a multiplication; sampled only when idle
//   multiplicand  in   WIDTH-bit signed operand M
//   multiplier    in   WIDTH-bit signed operand Q
//   mult_result   out  2*WIDTH-bit signed product M*Q (registered, held)
//   valid         out  one-cycle pulse marking a new mult_result
//   busy          out  high while a multiplication is in progress
// ---------------------------------------------------------------------------
module booth_multiplier #(
   parameter int unsigned WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplier,
   output logic [2*WIDTH-1:0]   mult_result,
   output logic                 valid,
   output logic                 busy
);

   localparam int unsigned AW = WIDTH + 1;            // accumulator width
   localparam int unsigned CW = $clog2(WIDTH + 1);    // step counter width
   localparam int unsigned RW = 2 * WIDTH;            // product width

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]    r_state, w_state_nxt;
   logic [AW-1:0] r_acc,   w_acc_nxt;
   logic [AW-1:0] r_m,     w_m_nxt;
   logic [WIDTH-1:0] r_q,  w_q_nxt;
   logic          r_qm1,   w_qm1_nxt;
   logic [CW-1:0] r_count, w_count_nxt;
   logic [RW-1:0] r_result, w_result_nxt;
   logic          r_valid, w_valid_nxt;
   logic          r_busy,  w_busy_nxt;

   logic [AW-1:0] w_sum;

   // Booth recoding of {q0, q-1}: add M on 01, subtract M on 10, else hold.
   // The extra accumulator bit keeps -M representable for M = -2^(WIDTH-1).
   always_comb begin
      w_sum = r_acc;
      case ({r_q[0], r_qm1})
         2'b01:   w_sum = r_acc + r_m;
         2'b10:   w_sum = r_acc - r_m;
         default: w_sum = r_acc;
      endcase
   end

   // Next-state and next-register logic.
   always_comb begin
      w_state_nxt  = r_state;
      w_acc_nxt    = r_acc;
      w_m_nxt      = r_m;
      w_q_nxt      = r_q;
      w_qm1_nxt    = r_qm1;
      w_count_nxt  = r_count;
      w_result_nxt = r_result;
      w_valid_nxt  = 1'b0;
      w_busy_nxt   = r_busy;

      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_m_nxt     = {multiplicand[WIDTH-1], multiplicand};
               w_q_nxt     = multiplier;
               w_acc_nxt   = '0;
               w_qm1_nxt   = 1'b0;
               w_count_nxt = CW'(WIDTH);
               w_busy_nxt  = 1'b1;
               w_state_nxt = S_CALC;
            end
         end

         S_CALC: begin
            // Arithmetic shift right of {acc, q, q-1} after the add/sub.
            w_acc_nxt   = {w_sum[AW-1], w_sum[AW-1:1]};
            w_q_nxt     = {w_sum[0], r_q[WIDTH-1:1]};
            w_qm1_nxt   = r_q[0];
            w_count_nxt = r_count - CW'(1);
            if (r_count == CW'(1)) begin
               w_state_nxt = S_DONE;
            end
         end

         S_DONE: begin
            w_result_nxt = {r_acc[WIDTH-1:0], r_q};
            w_valid_nxt  = 1'b1;
            w_busy_nxt   = 1'b0;
            w_state_nxt  = S_IDLE;
         end

         default: begin
            w_state_nxt = S_IDLE;
            w_busy_nxt  = 1'b0;
         end
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_acc    <= '0;
         r_m      <= '0;
         r_q      <= '0;
         r_qm1    <= 1'b0;
         r_count  <= '0;
         r_result <= '0;
         r_valid  <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_acc    <= w_acc_nxt;
         r_m      <= w_m_nxt;
         r_q      <= w_q_nxt;
         r_qm1    <= w_qm1_nxt;
         r_count  <= w_count_nxt;
         r_result <= w_result_nxt;
         r_valid  <= w_valid_nxt;
         r_busy   <= w_busy_nxt;
      end
   end

   assign mult_result = r_result;
   assign valid       = r_valid;
   assign busy        = r_busy;

endmodule

// File: tb/tb_booth_multiplier.sv
// ---------------------------------------------------------------------------
// tb_booth_multiplier
//   Directed and randomized checks of booth_multiplier (WIDTH=8) against a
//   plain signed-multiply reference, including latency, valid width, busy,
//   ignored start while busy, back-to-back start and mid-operation reset.
// ---------------------------------------------------------------------------
module tb_booth_multiplier;

   localparam int unsigned W   = 8;
   localparam int unsigned LAT = W + 1;

   logic            clk;
   logic            reset;
   logic            start;
   logic [W-1:0]    multiplicand;
   logic [W-1:0]    multiplier;
   logic [2*W-1:0]  mult_result;
   logic            valid;
   logic            busy;

   int total = 0;
   int bad   = 0;
   logic [2*W-1:0] last_res;

   booth_multiplier #(.WIDTH(W)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .mult_result  (mult_result),
      .valid        (valid),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Signed reference product.
   function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] m, input logic [W-1:0] q);
      int sm;
      int sq;
      sm = $signed(m);
      sq = $signed(q);
      return (2*W)'(sm * sq);
   endfunction

   // Runs one multiplication. start is presented in the cycle before the
   // sampling edge. If inj > 0, a second start (2x2) is pulsed in cycle inj,
   // which must be ignored. Operands are scrambled after sampling.
   task automatic do_op(input logic [W-1:0] m, input logic [W-1:0] q,
                        input int inj, input string tag);
      logic [2*W-1:0] exp;
      int  lat;
      bit  busy_ok;
      exp = ref_mul(m, q);
      @(negedge clk);
      start        = 1'b1;
      multiplicand = m;
      multiplier   = q;
      @(posedge clk); #1;
      chk({tag, "_busy_e0"}, 32'(busy), 32'd1);
      chk({tag, "_valid_low"}, 32'(valid), 32'd0);
      chk({tag, "_held"}, 32'(mult_result), 32'(last_res));
      lat     = 0;
      busy_ok = 1'b1;
      while (lat < 2 * LAT + 2) begin
         @(negedge clk);
         if (inj > 0 && lat == inj) begin
            start        = 1'b1;
            multiplicand = 8'd2;
            multiplier   = 8'd2;
         end else begin
            start        = 1'b0;
            multiplicand = 8'($urandom);
            multiplier   = 8'($urandom);
         end
         @(posedge clk); #1;
         lat++;
         if (valid) break;
         if (!busy) busy_ok = 1'b0;
      end
      start = 1'b0;
      chk({tag, "_latency"}, 32'(lat), 32'(LAT));
      chk({tag, "_valid"}, 32'(valid), 32'd1);
      chk({tag, "_result"}, 32'(mult_result), 32'(exp));
      chk({tag, "_busy_done"}, 32'(busy), 32'd0);
      chk({tag, "_busy_calc"}, 32'(busy_ok), 32'd1);
      last_res = exp;
   endtask

   initial begin
      bit seen;
      logic [W-1:0] rm;
      logic [W-1:0] rq;

      reset        = 1'b1;
      start        = 1'b0;
      multiplicand = '0;
      multiplier   = '0;
      last_res     = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_result", 32'(mult_result), 32'd0);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(posedge clk);

      do_op(8'd5, 8'd3, 0, "m5q3");
      chk("m5q3_const", 32'(mult_result), 32'h000F);
      @(posedge clk); #1;
      chk("m5q3_pulse_end", 32'(valid), 32'd0);

      do_op(8'hF9, 8'd6, 0, "m_7q6");
      chk("m_7q6_const", 32'(mult_result), 32'hFFD6);
      do_op(8'd0, 8'hFF, 0, "m0q_1");
      chk("m0q_1_const", 32'(mult_result), 32'h0000);
      do_op(8'h80, 8'h80, 0, "mminqmin");
      chk("mminqmin_const", 32'(mult_result), 32'h4000);
      do_op(8'h80, 8'h7F, 0, "mminqmax");
      chk("mminqmax_const", 32'(mult_result), 32'hC080);
      do_op(8'h7F, 8'h7F, 0, "mmaxqmax");
      chk("mmaxqmax_const", 32'(mult_result), 32'h3F01);

      // Start pulsed at cycle 4 is ignored; the next start lands in the
      // valid cycle and must be accepted with no gap.
      @(posedge clk); #1;
      do_op(8'd5, 8'd3, 4, "ign");
      chk("ign_const", 32'(mult_result), 32'h000F);
      do_op(8'd2, 8'd2, 0, "b2b");
      chk("b2b_const", 32'(mult_result), 32'h0004);
      seen = 1'b0;
      repeat (12) begin
         @(posedge clk); #1;
         if (valid) seen = 1'b1;
      end
      chk("no_extra_valid", 32'(seen), 32'd0);

      // Reset in cycle 5 of a -3 x -3 operation.
      @(negedge clk);
      start        = 1'b1;
      multiplicand = 8'hFD;
      multiplier   = 8'hFD;
      @(posedge clk); #1;
      chk("abort_busy_e0", 32'(busy), 32'd1);
      repeat (4) begin
         @(negedge clk);
         start = 1'b0;
         @(posedge clk);
      end
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("abort_result", 32'(mult_result), 32'd0);
      chk("abort_valid", 32'(valid), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      @(negedge clk);
      reset    = 1'b0;
      last_res = '0;
      seen     = 1'b0;
      repeat (15) begin
         @(posedge clk); #1;
         if (valid) seen = 1'b1;
      end
      chk("abort_no_valid", 32'(seen), 32'd0);
      do_op(8'hFD, 8'hFD, 0, "recover");
      chk("recover_const", 32'(mult_result), 32'h0009);

      for (int i = 0; i < 500; i++) begin
         rm = 8'($urandom);
         rq = 8'($urandom);
         do_op(rm, rq, 0, "rand");
      end
      @(posedge clk); #1;
      chk("rand_pulse_end", 32'(valid), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
